fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the decoder. Owns the PC, reads
//  imem over a req/ack handshake and hands one instruction at a time to the
//  decoder. Waits for the decoder to finish, then takes the next PC from the
//  decoder's offset/absolute-jump outputs. Strictly one instruction in flight.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC value loaded on reset
//  TIMEOUT_CYC   256            max cycles waiting on imem_ack or decoder completion
// PORTS
//  clk               in   1   clock, rising edge
//  rst               in   1   reset, asynchronous, active-high
//  halt              in   1   1: do not start a new fetch (an in-progress fetch completes)
//  imem_req          out  1   imem read request
//  imem_addr         out  32  imem read address (= pc_counter)
//  imem_rdata        in   32  imem read data, valid when imem_ack=1
//  imem_ack          in   1   imem read done, 1-cycle pulse
//  instruction_data  out  32  instruction presented to decoder
//  instruction_RDY_BSY out 1  1: instruction_data valid for decoder
//  decoder_rdy_bsy   in   1   1: decoder ready/idle, 0: decoder busy
//  pc_offset         in   13  signed PC offset from decoder (0 = fall-through)
//  pc_jump_address   in   32  absolute jump target from decoder
//  pc_absolute_flag  in   1   1: next PC = pc_jump_address
//  pc_counter        out  32  PC of current instruction
//  fetch_error       out  1   sticky error (timeout / misaligned target)
//  fetch_count       out  32  number of instructions fetched, wraps at 2^32
// BEHAVIOUR
//  Reset (async): pc_counter=RESET_PC, imem_req=0, imem_addr=RESET_PC,
//   instruction_data=0, instruction_RDY_BSY=0, fetch_error=0, fetch_count=0,
//   timeout counter=0, state=IDLE. Reset mid-operation aborts any outstanding req.
//   A late imem_ack after reset is ignored.
//  States:
//   IDLE:  halt=0 -> REQ; halt=1 -> stay.
//   REQ:   imem_req=1, imem_addr=pc_counter; held until imem_ack sampled 1.
//          Ack may arrive in the first REQ cycle. On ack: instruction_data<=imem_rdata,
//          fetch_count+1, imem_req<=0 -> ISSUE.
//   ISSUE: instruction_RDY_BSY=1, held until decoder_rdy_bsy sampled 0 (accept);
//          then instruction_RDY_BSY<=0 -> WAIT_DONE.
//   WAIT_DONE: wait decoder_rdy_bsy sampled 1 -> UPDATE.
//   UPDATE (1 cycle): pc_absolute_flag=1: pc <= {pc_jump_address[31:1],1'b0};
//          else pc_offset!=0: pc <= pc + sign_extend(pc_offset);
//          else pc <= pc + 4. Result[1:0]!=0 -> ERROR (pc not updated), else -> IDLE.
//   ERROR: all handshake outputs 0, fetch_error=1, stays until reset.
//  Timeout: counter clears on each state entry and counts in REQ, ISSUE, WAIT_DONE;
//   reaching TIMEOUT_CYC -> ERROR.
//  Latency: IDLE->REQ 1 cycle; ack->instruction_RDY_BSY 1 cycle; decoder
//   completion->next imem_req 2 cycles (UPDATE, IDLE).
//  Arithmetic: 32-bit modulo; PC wraps 32'hFFFF_FFFC+4 -> 0 with no error.
//  halt asserted mid-fetch: current instruction completes through UPDATE; stall in IDLE.
//  Decoder/imem inputs are only sampled in the states listed; ignored elsewhere.
// STRUCTURE
//  Shared header cpu_defs.vh: fetch state encodings, INSTR_WIDTH=32, PC_STEP=4.
//  One sub-module: next_pc_calc (combinational: pc, offset, jump, abs_flag ->
//  next_pc, misaligned). FSM, timeout counter and fetch_count stay in fetch_unit.
// TESTING
//  1 Reset with RESET_PC=32'h100: pc_counter=0x100, all handshakes 0, fetch_count=0.
//  2 Sequential: ack latency 3, decoder reports pc_offset=4 -> fetch addrs 0x100,0x104,0x108; count=3.
//  3 Branch: pc=0x20, pc_offset=13'h1FF8 (-8) -> next imem_addr=0x18; offset 0 -> 0x24.
//  4 Jump: abs=1, jump=0x201 -> pc=0x200; jump=0x202 -> fetch_error=1, no further imem_req.
//  5 Timeout: TIMEOUT_CYC=8, imem_ack never returns -> fetch_error=1 after 8 REQ cycles.
//  6 Async rst during WAIT_DONE; imem_ack same cycle as req; halt=1 -> no req until halt=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// ============================================================
// fetch_unit_pkg : shared types and constants for the fetch stage
// Rev 1.0
// ============================================================
`default_nettype none

package fetch_unit_pkg;

  localparam int          INSTR_WIDTH  = 32;
  localparam int          PC_WIDTH     = 32;
  localparam int          OFFSET_WIDTH = 13;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_UPDATE    = 3'd4,
    ST_ERROR     = 3'd5
  } fetch_state_t;

  function automatic logic [PC_WIDTH-1:0] sext_offset(input logic [OFFSET_WIDTH-1:0] off);
    return {{(PC_WIDTH-OFFSET_WIDTH){off[OFFSET_WIDTH-1]}}, off};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================
// fetch_unit_if : imem request/ack bus plus decoder handshake
// Rev 1.0
// ============================================================
`default_nettype none

interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic                    imem_req;
  logic [PC_WIDTH-1:0]     imem_addr;
  logic [INSTR_WIDTH-1:0]  imem_rdata;
  logic                    imem_ack;
  logic [INSTR_WIDTH-1:0]  instruction_data;
  logic                    instruction_RDY_BSY;
  logic                    decoder_rdy_bsy;
  logic [OFFSET_WIDTH-1:0] pc_offset;
  logic [PC_WIDTH-1:0]     pc_jump_address;
  logic                    pc_absolute_flag;

  modport master (
    output imem_req, imem_addr, instruction_data, instruction_RDY_BSY,
    input  imem_rdata, imem_ack, decoder_rdy_bsy, pc_offset,
           pc_jump_address, pc_absolute_flag
  );

  modport slave (
    input  imem_req, imem_addr, instruction_data, instruction_RDY_BSY,
    output imem_rdata, imem_ack, decoder_rdy_bsy, pc_offset,
           pc_jump_address, pc_absolute_flag
  );

endinterface

`default_nettype wire

// File: rtl/fetch_unit_next_pc_calc.sv
// ============================================================
// next_pc_calc : combinational next-PC selection and alignment check
// Rev 1.0
// ============================================================
`default_nettype none

module next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [PC_WIDTH-1:0]     pc,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic [PC_WIDTH-1:0]     jump,
  input  logic                    abs_flag,
  output logic [PC_WIDTH-1:0]     next_pc,
  output logic                    misaligned
);

  // Jump targets are halfword-forced; bit 0 never reaches the PC.
  logic unused_jump_lsb;
  assign unused_jump_lsb = jump[0];

  always_comb begin
    next_pc = pc + PC_STEP;
    if (abs_flag) begin
      next_pc = {jump[PC_WIDTH-1:1], 1'b0};
    end else if (offset != '0) begin
      next_pc = pc + sext_offset(offset);
    end
  end

  assign misaligned = |next_pc[1:0];

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================
// fetch_unit : single-outstanding instruction fetch with timeout
// Rev 1.0
// ============================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt,
  fetch_unit_if.master         bus,
  output logic [PC_WIDTH-1:0]  pc_counter,
  output logic                 fetch_error,
  output logic [31:0]          fetch_count
);

  localparam int            TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  fetch_state_t            state;
  logic [PC_WIDTH-1:0]     pc;
  logic                    req;
  logic [INSTR_WIDTH-1:0]  instr;
  logic                    rdy;
  logic                    err;
  logic [31:0]             count;
  logic [TMO_W-1:0]        tmo_cnt;

  logic [PC_WIDTH-1:0]     next_pc;
  logic                    misaligned;
  logic                    tmo_hit;

  next_pc_calc u_next_pc (
    .pc         (pc),
    .offset     (bus.pc_offset),
    .jump       (bus.pc_jump_address),
    .abs_flag   (bus.pc_absolute_flag),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      req     <= 1'b0;
      instr   <= '0;
      rdy     <= 1'b0;
      err     <= 1'b0;
      count   <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (!halt) begin
            req   <= 1'b1;
            state <= ST_REQ;
          end
        end

        ST_REQ: begin
          // A returning ack wins over a timeout landing in the same cycle.
          if (bus.imem_ack) begin
            instr   <= bus.imem_rdata;
            count   <= count + 32'd1;
            req     <= 1'b0;
            rdy     <= 1'b1;
            tmo_cnt <= '0;
            state   <= ST_ISSUE;
          end else if (tmo_hit) begin
            req   <= 1'b0;
            err   <= 1'b1;
            state <= ST_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        ST_ISSUE: begin
          if (!bus.decoder_rdy_bsy) begin
            rdy     <= 1'b0;
            tmo_cnt <= '0;
            state   <= ST_WAIT_DONE;
          end else if (tmo_hit) begin
            rdy   <= 1'b0;
            err   <= 1'b1;
            state <= ST_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        ST_WAIT_DONE: begin
          if (bus.decoder_rdy_bsy) begin
            tmo_cnt <= '0;
            state   <= ST_UPDATE;
          end else if (tmo_hit) begin
            err   <= 1'b1;
            state <= ST_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        ST_UPDATE: begin
          tmo_cnt <= '0;
          if (misaligned) begin
            err   <= 1'b1;
            state <= ST_ERROR;
          end else begin
            pc    <= next_pc;
            state <= ST_IDLE;
          end
        end

        ST_ERROR: begin
          req <= 1'b0;
          rdy <= 1'b0;
          err <= 1'b1;
        end

        default: begin
          req   <= 1'b0;
          rdy   <= 1'b0;
          err   <= 1'b1;
          state <= ST_ERROR;
        end
      endcase
    end
  end

  assign bus.imem_req            = req;
  assign bus.imem_addr           = pc;
  assign bus.instruction_data    = instr;
  assign bus.instruction_RDY_BSY = rdy;
  assign pc_counter              = pc;
  assign fetch_error             = err;
  assign fetch_count             = count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================
// tb_fetch_unit : randomized self-checking bench for fetch_unit
// Rev 1.0
// ============================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        halt;
  logic [31:0] pc_counter;
  logic        fetch_error;
  logic [31:0] fetch_count;

  int          total;
  int          bad;
  logic [31:0] m_pc;
  logic [31:0] m_count;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC    (32'h100),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .halt        (halt),
    .bus         (bus),
    .pc_counter  (pc_counter),
    .fetch_error (fetch_error),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference next-PC from the architectural rules, plain 64-bit arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [12:0] off,
                                           input logic [31:0] jmp, input logic abs);
    longint t;
    if (abs) return jmp & 32'hFFFF_FFFE;
    if (off != 13'd0) t = longint'(pc) + longint'($signed(off));
    else              t = longint'(pc) + 64'sd4;
    return t[31:0];
  endfunction

  task automatic scramble(input bit with_ack);
    bus.pc_offset        = 13'($urandom);
    bus.pc_jump_address  = $urandom;
    bus.pc_absolute_flag = 1'($urandom);
    bus.imem_rdata       = $urandom;
    if (with_ack) bus.imem_ack = 1'($urandom);
  endtask

  task automatic apply_reset(input logic halt_after);
    bus.imem_ack        = 1'b0;
    bus.decoder_rdy_bsy = 1'b1;
    halt = halt_after;
    rst  = 1'b1;
    tick();
    tick();
    rst     = 1'b0;
    m_pc    = 32'h100;
    m_count = 32'd0;
  endtask

  task automatic do_fetch(input int ack_lat, input int hold, input int busy,
                          input logic [12:0] off, input logic [31:0] jmp, input logic abs);
    logic [31:0] rdata;
    logic [31:0] nxt;
    int          waited;
    waited = 0;
    while (bus.imem_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    total++;
    if (bus.imem_req !== 1'b1) begin
      bad++;
      $display("FAIL req_wait: imem_req=%b required 1", bus.imem_req);
      return;
    end
    total++;
    if (bus.imem_addr !== m_pc) begin
      bad++;
      $display("FAIL imem_addr: got %h required %h", bus.imem_addr, m_pc);
    end
    for (int i = 0; i < ack_lat; i++) begin
      scramble(1'b0);
      tick();
    end
    rdata = $urandom;
    bus.imem_rdata = rdata;
    bus.imem_ack   = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    m_count++;
    total++;
    if (bus.instruction_RDY_BSY !== 1'b1 || bus.instruction_data !== rdata || bus.imem_req !== 1'b0) begin
      bad++;
      $display("FAIL issue: rdy=%b data=%h req=%b required rdy=1 data=%h req=0",
               bus.instruction_RDY_BSY, bus.instruction_data, bus.imem_req, rdata);
    end
    total++;
    if (fetch_count !== m_count) begin
      bad++;
      $display("FAIL fetch_count: got %0d required %0d", fetch_count, m_count);
    end
    for (int i = 0; i < hold; i++) begin
      scramble(1'b1);
      tick();
    end
    total++;
    if (bus.instruction_RDY_BSY !== 1'b1) begin
      bad++;
      $display("FAIL issue_hold: rdy=%b required 1", bus.instruction_RDY_BSY);
    end
    bus.decoder_rdy_bsy = 1'b0;
    scramble(1'b1);
    tick();
    total++;
    if (bus.instruction_RDY_BSY !== 1'b0) begin
      bad++;
      $display("FAIL accept: rdy=%b required 0", bus.instruction_RDY_BSY);
    end
    for (int i = 0; i < busy; i++) begin
      scramble(1'b1);
      tick();
    end
    bus.imem_ack         = 1'b0;
    bus.pc_offset        = off;
    bus.pc_jump_address  = jmp;
    bus.pc_absolute_flag = abs;
    bus.decoder_rdy_bsy  = 1'b1;
    tick();
    tick();
    scramble(1'b0);
    nxt = ref_next(m_pc, off, jmp, abs);
    if (nxt[1:0] != 2'b00) begin
      total++;
      if (fetch_error !== 1'b1 || bus.imem_req !== 1'b0 || pc_counter !== m_pc) begin
        bad++;
        $display("FAIL misalign: err=%b req=%b pc=%h required err=1 req=0 pc=%h",
                 fetch_error, bus.imem_req, pc_counter, m_pc);
      end
    end else begin
      total++;
      if (fetch_error !== 1'b0 || bus.imem_req !== 1'b0 || pc_counter !== nxt) begin
        bad++;
        $display("FAIL update: err=%b req=%b pc=%h required err=0 req=0 pc=%h",
                 fetch_error, bus.imem_req, pc_counter, nxt);
      end
      m_pc = nxt;
      if (!halt) begin
        tick();
        total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) begin
          bad++;
          $display("FAIL next_req: req=%b addr=%h required req=1 addr=%h",
                   bus.imem_req, bus.imem_addr, m_pc);
        end
      end
    end
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    total++;
    if (pc_counter !== 32'h100 || bus.imem_addr !== 32'h100) begin
      bad++;
      $display("FAIL reset_pc: pc=%h addr=%h required 00000100", pc_counter, bus.imem_addr);
    end
    total++;
    if (bus.imem_req !== 1'b0 || bus.instruction_RDY_BSY !== 1'b0 || bus.instruction_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_hs: req=%b rdy=%b data=%h required 0", bus.imem_req,
               bus.instruction_RDY_BSY, bus.instruction_data);
    end
    total++;
    if (fetch_error !== 1'b0 || fetch_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_status: err=%b count=%0d required 0", fetch_error, fetch_count);
    end
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (bus.imem_req !== 1'b0) begin
      bad++;
      $display("FAIL halt_idle: req=%b required 0", bus.imem_req);
    end
    halt = 1'b0;
    tick();
    total++;
    if (bus.imem_req !== 1'b1) begin
      bad++;
      $display("FAIL idle_to_req: req=%b required 1", bus.imem_req);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) do_fetch(3, 0, 1, 13'd4, 32'd0, 1'b0);
    total++;
    if (fetch_count !== 32'd3 || m_pc !== 32'h10C) begin
      bad++;
      $display("FAIL sequential: count=%0d pc=%h required 3 0000010c", fetch_count, m_pc);
    end
  endtask

  task automatic test_branch();
    do_fetch(1, 1, 0, 13'd0, 32'h20, 1'b1);
    do_fetch(2, 0, 2, 13'd0, 32'd0, 1'b0);
    do_fetch(0, 2, 0, 13'd0, 32'h20, 1'b1);
    do_fetch(0, 0, 0, 13'h1FF8, 32'd0, 1'b0);
    total++;
    if (pc_counter !== 32'h18) begin
      bad++;
      $display("FAIL branch_back: pc=%h required 00000018", pc_counter);
    end
  endtask

  task automatic test_wrap();
    do_fetch(1, 0, 0, 13'd0, 32'hFFFF_FFFC, 1'b1);
    do_fetch(0, 0, 0, 13'd0, 32'd0, 1'b0);
    total++;
    if (pc_counter !== 32'd0 || fetch_error !== 1'b0) begin
      bad++;
      $display("FAIL wrap_fwd: pc=%h err=%b required 00000000 0", pc_counter, fetch_error);
    end
    do_fetch(2, 1, 1, 13'h1FFC, 32'd0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [12:0] off;
    logic [31:0] jmp;
    logic        abs;
    for (int n = 0; n < 20; n++) begin
      r   = $urandom;
      off = 13'($urandom) & 13'h1FFC;
      jmp = ($urandom & 32'hFFFF_FFFC) | {31'd0, r[5]};
      abs = (r[1:0] == 2'b00);
      do_fetch(int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 4)), off, jmp, abs);
    end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    do_fetch(2, 1, 1, 13'd8, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (bus.imem_req !== 1'b0) begin
      bad++;
      $display("FAIL halt_stall: req=%b required 0", bus.imem_req);
    end
    halt = 1'b0;
    tick();
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) begin
      bad++;
      $display("FAIL halt_release: req=%b addr=%h required 1 %h", bus.imem_req, bus.imem_addr, m_pc);
    end
  endtask

  task automatic test_async_reset();
    bus.imem_rdata = 32'hDEAD_BEEF;
    bus.imem_ack   = 1'b1;
    tick();
    bus.imem_ack        = 1'b0;
    bus.decoder_rdy_bsy = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    halt = 1'b1;
    #1;
    total++;
    if (pc_counter !== 32'h100 || bus.imem_req !== 1'b0 || bus.instruction_RDY_BSY !== 1'b0 ||
        fetch_count !== 32'd0 || bus.instruction_data !== 32'd0 || fetch_error !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: pc=%h req=%b rdy=%b count=%0d data=%h err=%b",
               pc_counter, bus.imem_req, bus.instruction_RDY_BSY, fetch_count,
               bus.instruction_data, fetch_error);
    end
    tick();
    rst                 = 1'b0;
    bus.decoder_rdy_bsy = 1'b1;
    bus.imem_ack        = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    tick();
    total++;
    if (fetch_count !== 32'd0 || bus.instruction_RDY_BSY !== 1'b0 || bus.imem_req !== 1'b0) begin
      bad++;
      $display("FAIL late_ack: count=%0d rdy=%b req=%b required 0 0 0",
               fetch_count, bus.instruction_RDY_BSY, bus.imem_req);
    end
    m_pc    = 32'h100;
    m_count = 32'd0;
    halt    = 1'b0;
    do_fetch(0, 0, 0, 13'd0, 32'd0, 1'b0);
  endtask

  task automatic test_jump_error();
    do_fetch(1, 0, 0, 13'd0, 32'h201, 1'b1);
    do_fetch(1, 0, 0, 13'd0, 32'h202, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (bus.imem_req !== 1'b0 || fetch_error !== 1'b1) begin
        bad++;
        $display("FAIL error_sticky: req=%b err=%b required 0 1", bus.imem_req, fetch_error);
      end
    end
  endtask

  task automatic test_timeout();
    int waited;
    apply_reset(1'b0);
    waited = 0;
    while (bus.imem_req !== 1'b1 && waited < 5) begin
      tick();
      waited++;
    end
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (fetch_error !== 1'b0 || bus.imem_req !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early: err=%b req=%b required 0 1", fetch_error, bus.imem_req);
    end
    tick();
    total++;
    if (fetch_error !== 1'b1 || bus.imem_req !== 1'b0) begin
      bad++;
      $display("FAIL timeout: err=%b req=%b required 1 0", fetch_error, bus.imem_req);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    halt  = 1'b1;
    rst   = 1'b0;
    bus.imem_ack         = 1'b0;
    bus.imem_rdata       = 32'd0;
    bus.decoder_rdy_bsy  = 1'b1;
    bus.pc_offset        = 13'd0;
    bus.pc_jump_address  = 32'd0;
    bus.pc_absolute_flag = 1'b0;
    m_pc    = 32'h100;
    m_count = 32'd0;
    tick();
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_random();
    test_halt();
    test_async_reset();
    test_jump_error();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
